// File: rtl/phase_average_pkg.sv
// Shared types, phase constants and the phase-wrap helper for phase_average.
package phase_average_pkg;

  typedef logic signed [31:0] q24_8_t;

  localparam logic signed [32:0] DEG180_Q = 33'sd46080;
  localparam logic signed [32:0] DEG360_Q = 33'sd92160;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    OUTPUT = 2'd2
  } pa_state_t;

  // B-A folded back into [-180,180) degrees
  function automatic logic signed [32:0] wrap_phase(input q24_8_t a, input q24_8_t b);
    logic signed [32:0] d;
    d = {b[31], b} - {a[31], a};
    if (d >= DEG180_Q) begin
      wrap_phase = d - DEG360_Q;
    end else if (d < -DEG180_Q) begin
      wrap_phase = d + DEG360_Q;
    end else begin
      wrap_phase = d;
    end
  endfunction

endpackage

// File: rtl/phase_average_udiv.sv
// udiv_serial: restoring unsigned divider, one quotient bit per cycle, W cycles from start to done.
module udiv_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_r;
  logic [W-1:0]  q_r;
  logic [CW-1:0] cnt_r;
  logic          running_r;
  logic          done_r;
  logic [2*W-1:0] load_s;
  logic [2*W-1:0] step_s;

  // One restoring step: shift in the next dividend bit, subtract when it fits
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, input logic [W-1:0] q,
                                               input logic [W-1:0] d);
    logic [W:0] trial;
    trial = {rem, q[W-1]};
    if (trial >= {1'b0, d}) begin
      div_step = {trial[W-1:0] - d, q[W-2:0], 1'b1};
    end else begin
      div_step = {trial[W-1:0], q[W-2:0], 1'b0};
    end
  endfunction

  assign load_s = div_step({W{1'b0}}, dividend, divisor);
  assign step_s = div_step(rem_r, q_r, divisor);

  // Iteration state; the start edge already performs the first step
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_r     <= '0;
      q_r       <= '0;
      cnt_r     <= '0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (start) begin
      {rem_r, q_r} <= load_s;
      cnt_r        <= CW'(W - 1);
      running_r    <= 1'b1;
      done_r       <= 1'b0;
    end else if (running_r) begin
      {rem_r, q_r} <= step_s;
      cnt_r        <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        running_r <= 1'b0;
        done_r    <= 1'b1;
      end else begin
        done_r    <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign quotient = q_r;
  assign done     = done_r;

endmodule

// File: rtl/phase_average.sv
// phase_average: averages RUNS single-beat peak results (freq, mag, wrapped B-A phase).
// Optional build macro PHASE_AVG_FREQ_CHECK_EN rejects runs far from the block's first accepted freq.
import phase_average_pkg::*;

module phase_average #(
  parameter  int RUNS     = 8,
  parameter  int MAG_MIN  = 256,
  parameter  int FREQ_TOL = 256,
  localparam int CNT_W    = $clog2(RUNS + 1),
  localparam int ACC_W    = 33 + $clog2(RUNS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic             sink_valid,
  input  logic [31:0]      sink_freq,
  input  logic [31:0]      sink_mag,
  input  logic [31:0]      sink_phaseA,
  input  logic [31:0]      sink_phaseB,
  output logic             source_valid,
  output logic [31:0]      source_freq,
  output logic [31:0]      source_mag,
  output logic [31:0]      source_phase,
  output logic [CNT_W-1:0] source_count,
  output logic             busy,
  output logic             drop
);
  localparam q24_8_t MAG_MIN_Q = q24_8_t'(MAG_MIN);

  pa_state_t state_r, next_state_s;
  logic signed [ACC_W-1:0] acc_f_r, acc_m_r, acc_p_r;
  logic [CNT_W-1:0] n_r, run_cnt_r, n_nxt_s;
  logic run_beat_s, accept_s, freq_ok_s, div_start_r;
  logic signed [32:0] d_s;
  logic [ACC_W-1:0] divisor_s, quot_f_s, quot_m_s, quot_p_s;
  logic done_f_s, done_m_s, done_p_s;
  logic source_valid_r, busy_r, drop_r;
  logic [31:0] source_freq_r, source_mag_r, source_phase_r;
  logic [CNT_W-1:0] source_count_r;

  function automatic logic [ACC_W-1:0] mag_of(input logic signed [ACC_W-1:0] v);
    mag_of = v[ACC_W-1] ? -v : v;
  endfunction

  function automatic logic [31:0] signed_mean(input logic neg, input logic [ACC_W-1:0] q);
    logic [ACC_W-1:0] s;
    s = neg ? -q : q;
    signed_mean = s[31:0];
  endfunction

  assign run_beat_s = sink_valid && sink_sop && sink_eop && (state_r == ACCUM);
  assign d_s        = wrap_phase(q24_8_t'(sink_phaseA), q24_8_t'(sink_phaseB));
  assign accept_s   = run_beat_s && ($signed(sink_mag) >= MAG_MIN_Q) && freq_ok_s;
  assign n_nxt_s    = accept_s ? (n_r + CNT_W'(1)) : n_r;
  assign divisor_s  = ACC_W'(n_r);

`ifdef PHASE_AVG_FREQ_CHECK_EN
  localparam logic signed [32:0] FTOL_Q = 33'(FREQ_TOL);
  q24_8_t f_ref_r;
  logic signed [32:0] fdiff_s;

  assign fdiff_s   = {sink_freq[31], sink_freq} - {f_ref_r[31], f_ref_r};
  assign freq_ok_s = (n_r == '0) || ((fdiff_s <= FTOL_Q) && (fdiff_s >= -FTOL_Q));

  // Reference frequency taken from the first accepted run of each block
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_ref_r <= '0;
    end else if (accept_s && (n_r == '0)) begin
      f_ref_r <= q24_8_t'(sink_freq);
    end else begin
      f_ref_r <= f_ref_r;
    end
  end
`else
  assign freq_ok_s = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (run_beat_s && (run_cnt_r == CNT_W'(RUNS - 1))) begin
          next_state_s = DIVIDE;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DIVIDE: begin
        if ((n_r == '0) || done_f_s) begin
          next_state_s = OUTPUT;
        end else begin
          next_state_s = DIVIDE;
        end
      end
      OUTPUT:  next_state_s = ACCUM;
      default: next_state_s = ACCUM;
    endcase
  end

  // Accumulation, result capture and status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_f_r <= '0; acc_m_r <= '0; acc_p_r <= '0;
      n_r <= '0; run_cnt_r <= '0; div_start_r <= 1'b0;
      source_valid_r <= 1'b0; busy_r <= 1'b0; drop_r <= 1'b0;
      source_freq_r <= '0; source_mag_r <= '0; source_phase_r <= '0; source_count_r <= '0;
    end else begin
      source_valid_r <= 1'b0;
      busy_r         <= (next_state_s != ACCUM);
      // an empty block never starts the dividers, so no stale done can leak into a later block
      div_start_r    <= (state_r == ACCUM) && (next_state_s == DIVIDE) && (n_nxt_s != '0);
      if (sink_valid && (!(sink_sop && sink_eop) || (state_r != ACCUM))) begin
        drop_r <= 1'b1;
      end
      case (state_r)
        ACCUM: begin
          if (run_beat_s) begin
            run_cnt_r <= run_cnt_r + CNT_W'(1);
          end
          if (accept_s) begin
            acc_f_r <= acc_f_r + ACC_W'($signed(sink_freq));
            acc_m_r <= acc_m_r + ACC_W'($signed(sink_mag));
            acc_p_r <= acc_p_r + ACC_W'(d_s);
            n_r     <= n_nxt_s;
          end
        end
        DIVIDE: begin
          run_cnt_r <= run_cnt_r;
        end
        OUTPUT: begin
          source_valid_r <= 1'b1;
          source_count_r <= n_r;
          if (n_r == '0) begin
            source_freq_r  <= '0;
            source_mag_r   <= '0;
            source_phase_r <= '0;
          end else begin
            source_freq_r  <= signed_mean(acc_f_r[ACC_W-1], quot_f_s);
            source_mag_r   <= signed_mean(acc_m_r[ACC_W-1], quot_m_s);
            source_phase_r <= signed_mean(acc_p_r[ACC_W-1], quot_p_s);
          end
          acc_f_r <= '0; acc_m_r <= '0; acc_p_r <= '0;
          n_r <= '0; run_cnt_r <= '0;
        end
        default: begin
          run_cnt_r <= '0;
        end
      endcase
    end
  end

  udiv_serial #(.W(ACC_W)) u_div_f (
    .clk(clk), .reset_n(reset_n), .start(div_start_r), .dividend(mag_of(acc_f_r)),
    .divisor(divisor_s), .quotient(quot_f_s), .done(done_f_s)
  );
  udiv_serial #(.W(ACC_W)) u_div_m (
    .clk(clk), .reset_n(reset_n), .start(div_start_r), .dividend(mag_of(acc_m_r)),
    .divisor(divisor_s), .quotient(quot_m_s), .done(done_m_s)
  );
  udiv_serial #(.W(ACC_W)) u_div_p (
    .clk(clk), .reset_n(reset_n), .start(div_start_r), .dividend(mag_of(acc_p_r)),
    .divisor(divisor_s), .quotient(quot_p_s), .done(done_p_s)
  );

  assign source_valid = source_valid_r;
  assign source_freq  = source_freq_r;
  assign source_mag   = source_mag_r;
  assign source_phase = source_phase_r;
  assign source_count = source_count_r;
  assign busy         = busy_r;
  assign drop         = drop_r;

endmodule

// File: tb/tb_phase_average.sv
// Scoreboard bench for phase_average (RUNS=4): reference model computes block means from the beats sent.
module tb_phase_average;
  localparam int RUNS  = 4;
  localparam int ACC_W = 35;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
  logic [31:0] sink_freq = 32'd0, sink_mag = 32'd0, sink_phaseA = 32'd0, sink_phaseB = 32'd0;
  logic source_valid, busy, drop;
  logic [31:0] source_freq, source_mag, source_phase;
  logic [CNT_W-1:0] source_count;

  phase_average #(.RUNS(RUNS)) dut (
    .clk(clk), .reset_n(reset_n), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_valid(sink_valid), .sink_freq(sink_freq), .sink_mag(sink_mag),
    .sink_phaseA(sink_phaseA), .sink_phaseB(sink_phaseB), .source_valid(source_valid),
    .source_freq(source_freq), .source_mag(source_mag), .source_phase(source_phase),
    .source_count(source_count), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int f; int m; int a; int b; } beat_t;
  typedef struct { int f; int m; int p; int c; int due; } res_t;

  beat_t blk[$];
  res_t  exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Block result straight from the rules: wrapped difference, magnitude gate, mean truncated toward zero
  function automatic res_t model();
    res_t r;
    longint sf = 0, sm = 0, sp = 0, fref = 0, d;
    int n = 0;
    bit ok;
    foreach (blk[i]) begin
      ok = (blk[i].m >= 256);
`ifdef PHASE_AVG_FREQ_CHECK_EN
      if (ok && n > 0 && ((longint'(blk[i].f) - fref > 256) || (fref - longint'(blk[i].f) > 256)))
        ok = 0;
`endif
      if (ok) begin
        if (n == 0) fref = blk[i].f;
        d = longint'(blk[i].b) - longint'(blk[i].a);
        if (d >= 46080) d = d - 92160;
        else if (d < -46080) d = d + 92160;
        sf += blk[i].f; sm += blk[i].m; sp += d;
        n++;
      end
    end
    r.c = n;
    if (n == 0) begin
      r.f = 0; r.m = 0; r.p = 0;
    end else begin
      r.f = int'(sf / n); r.m = int'(sm / n); r.p = int'(sp / n);
    end
    r.due = 0;
    return r;
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int f, input int m, input int a, input int b,
                      input bit sop = 1'b1, input bit eop = 1'b1, input bit track = 1'b1);
    beat_t bt;
    res_t r;
    sink_freq = f; sink_mag = m; sink_phaseA = a; sink_phaseB = b;
    sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    if (track) begin
      bt.f = f; bt.m = m; bt.a = a; bt.b = b;
      blk.push_back(bt);
      if (blk.size() == RUNS) begin
        r = model();
        r.due = cyc + ((r.c == 0) ? 2 : ACC_W + 2);
        exp_q.push_back(r);
        blk.delete();
      end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", source_valid, 0);
    check("rst_freq", source_freq, 0);
    check("rst_mag", source_mag, 0);
    check("rst_phase", source_phase, 0);
    check("rst_count", source_count, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    reset_n = 1'b1;
    blk.delete();
    exp_q.delete();
  endtask

  // Monitor: every result strobe is matched against the oldest expected block
  always @(negedge clk) begin
    if (reset_n && source_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("freq", $signed(source_freq), r.f);
        check("mag", $signed(source_mag), r.m);
        check("phase", $signed(source_phase), r.p);
        check("count", source_count, r.c);
        check("latency", cyc, r.due);
      end
    end
  end

  initial begin
    idle(2);
    do_reset();

    // 10 -> 40 deg, mag 2.0, 100 kHz
    for (int i = 0; i < 4; i++) send(25600, 512, 2560, 10240);
    wait_idle();

    // wrap across +/-180
    for (int i = 0; i < 4; i++) send(25600, 512, 43520, -43520);
    wait_idle();
    for (int i = 0; i < 4; i++) send(25600, 512, -43520, 43520);
    wait_idle();

    // weak runs counted but not summed; then an all-weak block
    send(25600, 512, 0, 7680);
    send(25600, 128, 0, 40000);
    send(25600, 512, 0, 23040);
    send(25600, 128, 0, -40000);
    wait_idle();
    for (int i = 0; i < 4; i++) send(25600, 128, 0, 7680);
    wait_idle();

    // beat while busy is dropped and does not disturb the result
    for (int i = 0; i < 3; i++) send(25600, 768, 0, 5120);
    send(25600, 768, 0, 5120);
    send(99999, 9999, 0, 46000, 1'b1, 1'b1, 1'b0);
    check("busy_in_divide", busy, 1);
    check("drop_busy_beat", drop, 1);
    wait_idle();

    // malformed beat sets drop without counting as a run
    do_reset();
    send(25600, 512, 0, 46000, 1'b1, 1'b0, 1'b0);
    check("drop_malformed", drop, 1);
    for (int i = 0; i < 4; i++) send(25600, 512, 0, 7680);
    wait_idle();

    // partial block discarded by reset
    send(25600, 512, 0, 23040);
    send(25600, 512, 0, 23040);
    do_reset();
    for (int i = 0; i < 4; i++) send(25600, 512, 0, 7680);
    wait_idle();

    // frequency spread {100, 100.5, 102, 100} kHz
    send(25600, 512, 0, 7680);
    send(25728, 512, 0, 7680);
    send(26112, 512, 0, 7680);
    send(25600, 512, 0, 7680);
    wait_idle();

    // randomized blocks with idle gaps
    for (int blkn = 0; blkn < 30; blkn++) begin
      for (int i = 0; i < RUNS; i++) begin
        idle($urandom_range(0, 2));
        send(25600 + int'($urandom_range(0, 1200)) - 600, int'($urandom_range(0, 1024)),
             int'($urandom_range(0, 92159)) - 46080, int'($urandom_range(0, 92159)) - 46080);
      end
      wait_idle();
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
